// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: the pipeline writeback has priority, and MDU results
// wait in a 2-entry in-order FIFO. WAW kill bits and RAW hazard detection cover queued MDU entries.
module writeback_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic [DATA_W-1:0] pipe_pc,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [4:0]        mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic [DATA_W-1:0] mdu_pc,
    input  logic [4:0]        rd_addr1,
    input  logic [4:0]        rd_addr2,
    output logic              raw_stall,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] rf_pc
);

    logic [4:0]        addr_q [2];
    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] pc_q   [2];
    logic [1:0]        kill_q;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              rf_we_q;
    logic [4:0]        rf_addr_q;
    logic [DATA_W-1:0] rf_data_q;
    logic [DATA_W-1:0] rf_pc_q;

    logic pipe_eff;
    logic mdu_accept;
    logic push;
    logic pop;
    logic stall;

    always_comb begin
        pipe_eff   = pipe_we && (pipe_addr != '0);
        mdu_ready  = !reset && (count_q != 2'd2);
        mdu_accept = mdu_valid && mdu_ready;
        // A same-address pipe write in this cycle is younger, so the MDU result is dropped.
        push       = mdu_accept && (mdu_addr != '0) && !(pipe_eff && (mdu_addr == pipe_addr));
        pop        = !pipe_eff && (count_q != 2'd0);
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)))) && !kill_q[i]) begin
                if (((rd_addr1 != '0) && (rd_addr1 == addr_q[i])) ||
                    ((rd_addr2 != '0) && (rd_addr2 == addr_q[i])))
                    stall = 1'b1;
            end
        end
        raw_stall = stall && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            kill_q    <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            rf_pc_q   <= '0;
        end else begin
            if (pipe_eff) begin
                rf_we_q   <= 1'b1;
                rf_addr_q <= pipe_addr;
                rf_data_q <= pipe_data;
                rf_pc_q   <= pipe_pc;
            end else if (pop) begin
                rf_we_q   <= ~kill_q[rd_ptr_q];
                rf_addr_q <= addr_q[rd_ptr_q];
                rf_data_q <= data_q[rd_ptr_q];
                rf_pc_q   <= pc_q[rd_ptr_q];
            end else begin
                rf_we_q   <= 1'b0;
            end

            for (int unsigned i = 0; i < 2; i++) begin
                if (pipe_eff && (addr_q[i] == pipe_addr))
                    kill_q[i] <= 1'b1;
            end

            // The push targets a free slot, so its kill clear must override any stale match above.
            if (push) begin
                addr_q[wr_ptr_q] <= mdu_addr;
                data_q[wr_ptr_q] <= mdu_data;
                pc_q[wr_ptr_q]   <= mdu_pc;
                kill_q[wr_ptr_q] <= 1'b0;
            end

            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;
    assign rf_pc   = rf_pc_q;

endmodule
